// File: rtl/transport_receive_pkg.sv
// Shared constants and the receive-state type for the transport receive path.
package transport_receive_pkg;

    localparam logic [7:0] HDR_CTRL  = 8'h40;
    localparam logic [7:0] HDR_AUDIO = 8'h80;
    localparam logic [7:0] TRAILER   = 8'hFF;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_HDR     = 2'b01;
    localparam logic [1:0] ERR_PAD     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_CTRL_HI,
        RX_CTRL_LO,
        RX_CTRL_PAD,
        RX_AU_HI,
        RX_AU_LO,
        RX_AU_TRAIL,
        RX_DROP
    } rx_state_e;

endpackage

// File: rtl/transport_receive_timeout.sv
// Idle-cycle counter: counts enabled cycles without a clear and flags expiry
// on the cycle after TIMEOUT idle cycles have been seen.
module rx_timeout #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q;

    assign expire_o = (cnt_q == TW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst_i || !en_i || clr_i || expire_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/transport_receive.sv
// Receive transport layer: parses header/payload/trailer packets back into
// 16-bit control and audio words, flagging framing errors and stalls.
module transport_receive
    import transport_receive_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byteIn,
    input  logic        byteValid,
    output logic [1:0]  cmd,
    output logic [15:0] data,
    output logic        dataValid,
    output logic        receiving,
    output logic        pktErr,
    output logic [1:0]  errCode
);

    localparam int unsigned CW = $clog2(PACKET_SIZE + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(PACKET_SIZE);
    localparam logic [CW-1:0] LAST_LO   = CW'(PACKET_SIZE - 1);

    rx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [7:0]    hi_q;
    logic [15:0]   ctrlWord_q;
    logic          padBad_q;
    logic          padBad_d;
    logic [1:0]    cmd_q;
    logic [15:0]   data_q;
    logic          dataValid_q;
    logic          receiving_q;
    logic          pktErr_q;
    logic [1:0]    errCode_q;
    logic          expire;

    // cnt_d is the 1-based position of the byte currently on byteIn
    assign cnt_d    = cnt_q + 1'b1;
    assign padBad_d = padBad_q | (byteIn != 8'h00);

    rx_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_i    (reset),
        .en_i     (state_q != RX_IDLE),
        .clr_i    (byteValid),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            ctrlWord_q  <= '0;
            padBad_q    <= 1'b0;
            cmd_q       <= CMD_IDLE;
            data_q      <= '0;
            dataValid_q <= 1'b0;
            receiving_q <= 1'b0;
            pktErr_q    <= 1'b0;
            errCode_q   <= ERR_NONE;
        end else begin
            dataValid_q <= 1'b0;
            pktErr_q    <= 1'b0;
            if (expire) begin
                // expiry wins over a byte arriving in the same cycle
                state_q     <= RX_IDLE;
                cnt_q       <= '0;
                receiving_q <= 1'b0;
                pktErr_q    <= 1'b1;
                errCode_q   <= ERR_TIMEOUT;
            end else if (byteValid) begin
                cnt_q <= cnt_d;
                case (state_q)
                    RX_IDLE: begin
                        padBad_q <= 1'b0;
                        if (byteIn == HDR_CTRL) begin
                            state_q     <= RX_CTRL_HI;
                            receiving_q <= 1'b1;
                        end else if (byteIn == HDR_AUDIO) begin
                            state_q     <= RX_AU_HI;
                            receiving_q <= 1'b1;
                        end else begin
                            state_q   <= RX_DROP;
                            pktErr_q  <= 1'b1;
                            errCode_q <= ERR_HDR;
                        end
                    end
                    RX_CTRL_HI: begin
                        hi_q    <= byteIn;
                        state_q <= RX_CTRL_LO;
                    end
                    RX_CTRL_LO: begin
                        ctrlWord_q <= {hi_q, byteIn};
                        state_q    <= RX_CTRL_PAD;
                    end
                    RX_CTRL_PAD: begin
                        padBad_q <= padBad_d;
                        if (cnt_d == LAST_BYTE) begin
                            state_q     <= RX_IDLE;
                            cnt_q       <= '0;
                            receiving_q <= 1'b0;
                            if (padBad_d) begin
                                pktErr_q  <= 1'b1;
                                errCode_q <= ERR_PAD;
                            end else begin
                                dataValid_q <= 1'b1;
                                cmd_q       <= CMD_CTRL;
                                data_q      <= ctrlWord_q;
                            end
                        end
                    end
                    RX_AU_HI: begin
                        hi_q    <= byteIn;
                        state_q <= RX_AU_LO;
                    end
                    RX_AU_LO: begin
                        dataValid_q <= 1'b1;
                        cmd_q       <= CMD_AUDIO;
                        data_q      <= {hi_q, byteIn};
                        state_q     <= (cnt_d == LAST_LO) ? RX_AU_TRAIL : RX_AU_HI;
                    end
                    RX_AU_TRAIL: begin
                        state_q     <= RX_IDLE;
                        cnt_q       <= '0;
                        receiving_q <= 1'b0;
                        if (byteIn != TRAILER) begin
                            pktErr_q  <= 1'b1;
                            errCode_q <= ERR_PAD;
                        end
                    end
                    RX_DROP: begin
                        if (cnt_d == LAST_BYTE) begin
                            state_q <= RX_IDLE;
                            cnt_q   <= '0;
                        end
                    end
                    default: begin
                        state_q     <= RX_IDLE;
                        cnt_q       <= '0;
                        receiving_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cmd       = cmd_q;
    assign data      = data_q;
    assign dataValid = dataValid_q;
    assign receiving = receiving_q;
    assign pktErr    = pktErr_q;
    assign errCode   = errCode_q;

endmodule

// File: tb/tb_transport_receive.sv
// Self-checking bench for transport_receive: packet table plus scoreboard.
module tb_transport_receive;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byteIn;
    logic        byteValid;
    logic [1:0]  cmd;
    logic [15:0] data;
    logic        dataValid;
    logic        receiving;
    logic        pktErr;
    logic [1:0]  errCode;

    transport_receive #(.PACKET_SIZE(16), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .byteIn    (byteIn),
        .byteValid (byteValid),
        .cmd       (cmd),
        .data      (data),
        .dataValid (dataValid),
        .receiving (receiving),
        .pktErr    (pktErr),
        .errCode   (errCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [1:0]  cmd;
        logic [15:0] data;
        logic [1:0]  code;
    } exp_t;

    typedef struct {
        logic [127:0] pkt;
        bit           valid_hdr;
        int unsigned  nwords;
        logic [1:0]   ecmd;
        logic [15:0]  w0;
        bit           has_err;
        logic [1:0]   ecode;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_word(input logic [1:0] c, input logic [15:0] d);
        exp_t x;
        x.is_err = 1'b0; x.cmd = c; x.data = d; x.code = 2'b00;
        sb.push_back(x);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t x;
        x.is_err = 1'b1; x.cmd = 2'b00; x.data = 16'h0; x.code = code;
        sb.push_back(x);
    endtask

    function automatic logic [127:0] mk_ctrl(input logic [7:0] hi, input logic [7:0] lo,
                                             input int unsigned badpos, input logic [7:0] badval);
        logic [127:0] p;
        p = '0;
        p[127 -: 8] = 8'h40;
        p[119 -: 8] = hi;
        p[111 -: 8] = lo;
        if (badpos != 0) p[127 - 8*badpos -: 8] = badval;
        return p;
    endfunction

    function automatic logic [127:0] mk_audio(input logic [15:0] base, input logic [7:0] trailer);
        logic [127:0] p;
        logic [15:0]  w;
        p = '0;
        p[127 -: 8] = 8'h80;
        for (int s = 0; s < 7; s++) begin
            w = base + 16'(s);
            p[127 - 8*(1 + 2*s) -: 8] = w[15:8];
            p[127 - 8*(2 + 2*s) -: 8] = w[7:0];
        end
        p[7:0] = trailer;
        return p;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        byteIn = b;
        byteValid = 1'b1;
        @(posedge clk);
        #1;
        byteValid = 1'b0;
        byteIn = 8'h00;
    endtask

    // Scoreboard consumer: every dataValid/pktErr pulse must match the next expectation
    always @(negedge clk) begin
        if (!reset && (dataValid || pktErr)) begin
            chk("dv_err_exclusive", {31'd0, dataValid & pktErr}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_output", {30'd0, dataValid, pktErr}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_kind", {31'd0, pktErr}, {31'd0, e.is_err});
                if (e.is_err) begin
                    chk("sb_errCode", {30'd0, errCode}, {30'd0, e.code});
                end else begin
                    chk("sb_cmd", {30'd0, cmd}, {30'd0, e.cmd});
                    chk("sb_data", {16'd0, data}, {16'd0, e.data});
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        bit          got;
        logic [127:0] p;

        vecs[0] = '{mk_ctrl(8'h12, 8'h34, 0, 8'h00), 1, 1, 2'b01, 16'h1234, 0, 2'b00};
        vecs[1] = '{mk_audio(16'h0001, 8'hFF),       1, 7, 2'b10, 16'h0001, 0, 2'b00};
        vecs[2] = '{{8'h55, {15{8'h40}}},            0, 0, 2'b00, 16'h0000, 1, 2'b01};
        vecs[3] = '{mk_ctrl(8'hAB, 8'hCD, 0, 8'h00), 1, 1, 2'b01, 16'hABCD, 0, 2'b00};
        vecs[4] = '{mk_ctrl(8'h56, 8'h78, 9, 8'h01), 1, 0, 2'b00, 16'h0000, 1, 2'b10};
        vecs[5] = '{mk_audio(16'h0101, 8'hFE),       1, 7, 2'b10, 16'h0101, 1, 2'b10};
        vecs[6] = '{mk_ctrl(8'h9A, 8'hBC, 15, 8'h00), 1, 1, 2'b01, 16'h9ABC, 0, 2'b00};
        vecs[7] = '{mk_audio(16'hFFF8, 8'hFF),       1, 7, 2'b10, 16'hFFF8, 0, 2'b00};

        reset = 1'b1;
        byteValid = 1'b0;
        byteIn = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd", {30'd0, cmd}, 32'd0);
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_dataValid", {31'd0, dataValid}, 32'd0);
        chk("rst_receiving", {31'd0, receiving}, 32'd0);
        chk("rst_pktErr", {31'd0, pktErr}, 32'd0);
        chk("rst_errCode", {30'd0, errCode}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table packets, sent back-to-back
        for (int v = 0; v < 8; v++) begin
            for (int unsigned k = 0; k < vecs[v].nwords; k++)
                push_word(vecs[v].ecmd, vecs[v].w0 + 16'(k));
            if (vecs[v].has_err) push_err(vecs[v].ecode);
            p = vecs[v].pkt;
            for (int i = 0; i < 16; i++) begin
                send_byte(p[127 - 8*i -: 8]);
                if (i == 0) chk("recv_after_hdr", {31'd0, receiving}, {31'd0, vecs[v].valid_hdr});
                if (i == 15) chk("recv_after_last", {31'd0, receiving}, 32'd0);
            end
        end

        // Control word latency: released exactly one cycle after byte 16
        push_word(2'b01, 16'hBEEF);
        p = mk_ctrl(8'hBE, 8'hEF, 0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            send_byte(p[127 - 8*i -: 8]);
            if (i == 14) chk("ctrl_no_early_dv", {31'd0, dataValid}, 32'd0);
            if (i == 15) chk("ctrl_dv_latency", {31'd0, dataValid}, 32'd1);
        end
        @(posedge clk);
        #1;
        chk("ctrl_dv_one_cycle", {31'd0, dataValid}, 32'd0);
        chk("ctrl_data_held", {16'd0, data}, 32'h0000BEEF);

        // Audio stall after byte 5: two samples, then timeout
        push_word(2'b10, 16'h0001);
        push_word(2'b10, 16'h0002);
        push_err(2'b11);
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h02);
        n = 0;
        got = 0;
        while (!got && n < TO + 20) begin
            @(negedge clk);
            n++;
            if (pktErr) got = 1;
        end
        chk("timeout_latency", n, TO + 2);
        chk("timeout_receiving", {31'd0, receiving}, 32'd0);
        chk("timeout_data_held", {16'd0, data}, 32'h00000002);
        @(posedge clk);
        #1;

        // Reset in the middle of a packet clears every output
        send_byte(8'h40);
        send_byte(8'h12);
        chk("pre_reset_receiving", {31'd0, receiving}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_cmd", {30'd0, cmd}, 32'd0);
        chk("midrst_data", {16'd0, data}, 32'd0);
        chk("midrst_dataValid", {31'd0, dataValid}, 32'd0);
        chk("midrst_receiving", {31'd0, receiving}, 32'd0);
        chk("midrst_pktErr", {31'd0, pktErr}, 32'd0);
        chk("midrst_errCode", {30'd0, errCode}, 32'd0);
        reset = 1'b0;

        push_word(2'b01, 16'hC0DE);
        p = mk_ctrl(8'hC0, 8'hDE, 0, 8'h00);
        for (int i = 0; i < 16; i++) send_byte(p[127 - 8*i -: 8]);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
